uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync2.sv | 26 ++
 rtl/uart_rx.sv | 157 +++++++++++++++
 tb/tb_uart_rx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default baud divisor.
// Also imported by the UART transmitter so both ends agree on the bit period.
package uart_pkg;

  // 50 MHz system clock / 19200 baud
  localparam int BAUD_CYCLES_DEFAULT = 2604;

  // Baud counter width; holds the default divisor with margin
  localparam int BAUD_CNT_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter so an idle-high serial line comes out of reset
// as idle and does not look like a start bit.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops resolve metastability before the value is used
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, LSB first, mid-bit sampling off a down-counting
// baud timer. Reports framing errors and a sticky overrun flag.
//
//   state | meaning
//   IDLE  | waiting for a synchronized falling edge on RX
//   START | half-bit wait, then recheck the start bit (rejects glitches)
//   DATA  | sample one data bit per baud period, eight in total
//   STOP  | sample the stop bit and publish the byte or flag a framing error
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_CYCLES = BAUD_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr
);

  localparam logic [BAUD_CNT_W-1:0] HALF_LOAD = BAUD_CNT_W'(BAUD_CYCLES / 2);
  localparam logic [BAUD_CNT_W-1:0] FULL_LOAD = BAUD_CNT_W'(BAUD_CYCLES);

  uart_state_e            state_q, state_d;
  logic                   rx_sync;
  logic                   rx_prev;
  logic                   rx_fall;
  logic [BAUD_CNT_W-1:0]  baud_cnt;
  logic                   baud_done;
  logic                   cnt_load;
  logic [BAUD_CNT_W-1:0]  cnt_load_val;
  logic [3:0]             bit_cnt;
  logic                   bit_clr;
  logic                   sample_data;
  logic [7:0]             shift_reg;
  logic                   byte_good;
  logic                   byte_bad;

  sync2 #(.RESET_VAL(1'b1)) u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (RX),
    .q     (rx_sync)
  );

  // Previous synchronized line value for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_prev <= 1'b1;
    else        rx_prev <= rx_sync;
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // The timer expires on the cycle its count would reach zero, so a load of N
  // gives exactly N clocks between successive actions.
  assign baud_done = (baud_cnt == BAUD_CNT_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath control
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = FULL_LOAD;
    bit_clr      = 1'b0;
    sample_data  = 1'b0;
    byte_good    = 1'b0;
    byte_bad     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d      = START;
          cnt_load     = 1'b1;
          cnt_load_val = HALF_LOAD;
          bit_clr      = 1'b1;
        end
      end
      START: begin
        if (baud_done) begin
          if (rx_sync) begin
            state_d = IDLE;
          end else begin
            state_d  = DATA;
            cnt_load = 1'b1;
          end
        end
      end
      DATA: begin
        if (baud_done) begin
          sample_data = 1'b1;
          cnt_load    = 1'b1;
          if (bit_cnt == 4'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_done) begin
          state_d = IDLE;
          if (rx_sync) byte_good = 1'b1;
          else         byte_bad  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Baud down-counter: reload on request, otherwise count toward zero and park
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              baud_cnt <= '0;
    else if (cnt_load)       baud_cnt <= cnt_load_val;
    else if (baud_cnt != '0) baud_cnt <= baud_cnt - BAUD_CNT_W'(1);
  end

  // Data bit counter, cleared at the start of every frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           bit_cnt <= 4'd0;
    else if (bit_clr)     bit_cnt <= 4'd0;
    else if (sample_data) bit_cnt <= bit_cnt + 4'd1;
  end

  // LSB arrives first, so shift right and insert at the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           shift_reg <= 8'h00;
    else if (sample_data) shift_reg <= {rx_sync, shift_reg[7:1]};
  end

  // Registered outputs; a completing byte takes priority over the consumer clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= 8'h00;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (byte_good) begin
        rx_data <= shift_reg;
        rdy     <= 1'b1;
        frm_err <= 1'b0;
        if (rdy)          ovr <= 1'b1;
        else if (clr_rdy) ovr <= 1'b0;
      end else begin
        if (byte_bad) frm_err <= 1'b1;
        if (clr_rdy) begin
          rdy <= 1'b0;
          ovr <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of frames with hand-computed results,
// plus hand-written sequences for glitch rejection, latency, clear/set
// collision and mid-frame reset.
module tb_uart_rx;

  localparam int B = 16;

  logic       clk;
  logic       rst_n;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr;

  int n_cmp;
  int n_bad;

  uart_rx #(.BAUD_CYCLES(B)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr     (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       clr;
    logic [7:0] exp_data;
    logic       exp_rdy;
    logic       exp_frm;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [7:0] d, input logic r,
                            input logic f, input logic o);
    check({name, ".rx_data"}, rx_data, d);
    check({name, ".rdy"}, {7'd0, rdy}, {7'd0, r});
    check({name, ".frm_err"}, {7'd0, frm_err}, {7'd0, f});
    check({name, ".ovr"}, {7'd0, ovr}, {7'd0, o});
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    RX = 1'b0;
    repeat (B) tick();
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (B) tick();
    end
    RX = stop;
    repeat (B) tick();
    RX = 1'b1;
    repeat (2 * B) tick();
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    tick();
    clr_rdy = 1'b0;
  endtask

  // Runaway guard
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    RX      = 1'b1;
    clr_rdy = 1'b0;

    vecs[0] = '{8'h9A, 1'b1, 1'b0, 8'h9A, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hB2, 1'b1, 1'b0, 8'hB2, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h55, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h0F, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h81, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1};

    repeat (3) tick();
    check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].clr) begin
        pulse_clr();
        check($sformatf("vec%0d.clr_rdy", i), {7'd0, rdy}, 8'h00);
        check($sformatf("vec%0d.clr_ovr", i), {7'd0, ovr}, 8'h00);
      end
      send_frame(vecs[i].data, vecs[i].stop);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_rdy,
                 vecs[i].exp_frm, vecs[i].exp_ovr);
    end

    // Short low glitch: false start, nothing changes
    RX = 1'b0;
    repeat (B / 4) tick();
    RX = 1'b1;
    repeat (3 * B) tick();
    check_outs("glitch", 8'h3C, 1'b1, 1'b0, 1'b1);

    // Latency from RX falling edge to rdy
    pulse_clr();
    n = 0;
    fork
      send_frame(8'h6B, 1'b1);
      begin
        while (!rdy && n < 400) begin
          tick();
          n++;
        end
      end
    join
    n_cmp++;
    if (n < 2 + B / 2 + 9 * B - 1 || n > 2 + B / 2 + 9 * B + 1) begin
      n_bad++;
      $display("FAIL latency: got %0d clocks expected %0d +/-1", n, 2 + B / 2 + 9 * B);
    end
    check("latency.rx_data", rx_data, 8'h6B);

    // clr_rdy on the same edge that completes a byte: the set wins
    pulse_clr();
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (2 + B / 2 + 9 * B) tick();
        clr_rdy = 1'b1;
        tick();
        clr_rdy = 1'b0;
      end
    join
    check_outs("clr_collide", 8'hC3, 1'b1, 1'b0, 1'b0);

    // Reset during bit 4 of 0xFF, then a clean frame
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (3 + B / 2 + 4 * B + B / 2) tick();
        rst_n = 1'b0;
        #1;
        check_outs("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
      end
    join
    check_outs("rst_after", 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1);
    check_outs("rst_next", 8'hA5, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
